// File: rtl/serial_frame_scheduler_if.sv
// Status inputs, UART transmitter handshake and debug outputs of the frame scheduler.
// The scheduler takes the master side; the UART/status side takes the slave side.
interface serial_frame_scheduler_if;
  logic [7:0]  D0;
  logic [7:0]  D1;
  logic [7:0]  D2;
  logic [63:0] map_obstacles;
  logic        tx_pronto;
  logic        tx_partida;
  logic [7:0]  tx_dados;
  logic        frame_done;
  logic        erro;
  logic [2:0]  db_estado;

  modport master (
    input  D0, D1, D2, map_obstacles, tx_pronto,
    output tx_partida, tx_dados, frame_done, erro, db_estado
  );

  modport slave (
    output D0, D1, D2, map_obstacles, tx_pronto,
    input  tx_partida, tx_dados, frame_done, erro, db_estado
  );
endinterface

// File: rtl/serial_frame_scheduler.sv
// Sends a 12-byte status frame (0xAA, D0..D2, 8 map bytes) byte-by-byte to a UART, periodically or on D0 change.
// First tx_partida 2 cycles after trigger; each next byte 1 cycle after tx_pronto; a stalled byte aborts the frame after TIMEOUT cycles.
module serial_frame_scheduler #(
  parameter int INTERVALO = 500000,
  parameter int TIMEOUT   = 100000
) (
  input logic                       clock,
  input logic                       reset,
  serial_frame_scheduler_if.master  bus
);

  localparam logic [2:0] ESPERA  = 3'd0;
  localparam logic [2:0] CAPTURA = 3'd1;
  localparam logic [2:0] ENVIA   = 3'd2;
  localparam logic [2:0] AGUARDA = 3'd3;
  localparam logic [2:0] FIM     = 3'd4;
  localparam logic [2:0] ERRO    = 3'd5;

  localparam int IW = $clog2(INTERVALO);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] INT_LAST = IW'(INTERVALO - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [IW-1:0] int_cnt;
  logic [WW-1:0] wd_cnt;
  logic [3:0]    byte_idx;
  logic [95:0]   frame_buf;
  logic [7:0]    d0_snap;
  logic          erro_q;
  logic          trig;
  logic [6:0]    bit_off;

  assign trig    = (int_cnt == INT_LAST) || (bus.D0 != d0_snap);
  assign bit_off = {byte_idx, 3'b000};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ESPERA;
      int_cnt   <= '0;
      wd_cnt    <= '0;
      byte_idx  <= '0;
      frame_buf <= '0;
      d0_snap   <= 8'h00;
      erro_q    <= 1'b0;
    end else begin
      case (state)
        ESPERA: begin
          if (trig) state <= CAPTURA;
          else      int_cnt <= int_cnt + IW'(1);
        end
        CAPTURA: begin
          // Byte k of the frame lives in frame_buf[8k +: 8].
          frame_buf <= {bus.map_obstacles, bus.D2, bus.D1, bus.D0, 8'hAA};
          d0_snap   <= bus.D0;
          byte_idx  <= '0;
          state     <= ENVIA;
        end
        ENVIA: begin
          wd_cnt <= '0;
          state  <= AGUARDA;
        end
        AGUARDA: begin
          // A tx_pronto arriving on the watchdog's last cycle still counts.
          if (bus.tx_pronto) begin
            if (byte_idx == 4'd11) begin
              state <= FIM;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= ENVIA;
            end
          end else if (wd_cnt == WD_LAST) begin
            state <= ERRO;
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        FIM: begin
          erro_q  <= 1'b0;
          int_cnt <= '0;
          state   <= ESPERA;
        end
        ERRO: begin
          erro_q  <= 1'b1;
          int_cnt <= '0;
          state   <= ESPERA;
        end
        default: state <= ESPERA;
      endcase
    end
  end

  assign bus.tx_partida = (state == ENVIA);
  assign bus.tx_dados   = frame_buf[bit_off +: 8];
  assign bus.frame_done = (state == FIM);
  assign bus.erro       = erro_q;
  assign bus.db_estado  = state;

endmodule
